apb_cmd_driver: RTL and testbench

Upstream APB master sequencer that feeds the APB protocol top (bridge + GPIO + UART slaves). It accepts queued bus commands (read/write, slave select, address, data) through a valid/ready interface. It plays each command out as an APB SETUP/ACCESS sequence on the protocol top's control inputs, and returns read data on a response strobe. It replaces hand-driven testbench stimulus, so firmware-style command streams can exercise GPIO and UART.

---
 rtl/apb_cmd_driver.sv | 142 ++++++++++++++
 tb/tb_apb_cmd_driver.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_driver.sv
// Command sequencer for the APB protocol top: queues bus commands in a small FIFO
// and plays each one out as a SETUP/ACCESS sequence, returning read data on a strobe.
module apb_cmd_driver #(
    parameter int DEPTH         = 4,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        pclk,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_sel,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        transfer,
    output logic [1:0]  Psel,
    output logic        pwrite,
    output logic        penable,
    output logic [4:0]  write_paddr,
    output logic [4:0]  apb_read_paddr,
    output logic [31:0] write_data,
    input  logic [31:0] apb_read_data_out,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_sel,
    output logic [4:0]  rsp_addr,
    output logic        cmd_err,
    output logic        busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int EW = 40;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state, state_nx;
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nx;
    logic [EW-1:0] head;
    logic          head_legal, push, take, drop, pop, last;
    logic [KW-1:0] cnt;
    logic          cur_write;
    logic [1:0]    cur_sel;
    logic [4:0]    cur_addr;
    logic [31:0]   cur_wdata;

    // FIFO entry layout: {write, sel[1:0], addr[4:0], wdata[31:0]}
    assign head       = mem[rd_ptr];
    assign head_legal = (head[38:37] == 2'd1) || (head[38:37] == 2'd2);
    assign last       = (state == ACCESS) && (cnt == '0);
    assign push       = cmd_valid && cmd_ready;
    // Illegal heads are only discarded from IDLE; an ACCESS exit just falls back to IDLE.
    assign take       = (count != '0) && head_legal && ((state == IDLE) || last);
    assign drop       = (count != '0) && !head_legal && (state == IDLE);
    assign pop        = take || drop;
    assign count_nx   = count + CW'(push) - CW'(pop);
    assign busy       = (count != '0) || (state != IDLE);

    always_ff @(posedge pclk) begin
        if (push) mem[wr_ptr] <= {cmd_write, cmd_sel, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge pclk) begin
        if (Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
            cmd_err   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_nx;
            cmd_ready <= (count_nx != CW'(DEPTH));
            cmd_err   <= drop;
        end
    end

    always_ff @(posedge pclk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (take) state_nx = SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (last) state_nx = take ? SETUP : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus fields derive from the current-command registers, which only change on a
    // pop, so they naturally hold their last values through IDLE.
    always_comb begin
        transfer       = (state != IDLE);
        penable        = (state == ACCESS);
        Psel           = (state != IDLE) ? cur_sel : 2'd0;
        pwrite         = cur_write;
        write_paddr    = cur_write ? cur_addr : 5'd0;
        write_data     = cur_write ? cur_wdata : 32'd0;
        apb_read_paddr = cur_write ? 5'd0 : cur_addr;
    end

    always_ff @(posedge pclk) begin
        if (Reset) begin
            cnt       <= '0;
            cur_write <= 1'b0;
            cur_sel   <= 2'd0;
            cur_addr  <= 5'd0;
            cur_wdata <= 32'd0;
        end else begin
            if (state == SETUP)       cnt <= KW'(ACCESS_CYCLES - 1);
            else if (state == ACCESS) cnt <= cnt - KW'(1);
            if (take) begin
                cur_write <= head[39];
                cur_sel   <= head[38:37];
                cur_addr  <= head[36:32];
                cur_wdata <= head[31:0];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (Reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_sel   <= 2'd0;
            rsp_addr  <= 5'd0;
        end else begin
            rsp_valid <= last && !cur_write;
            if (last && !cur_write) begin
                rsp_data <= apb_read_data_out;
                rsp_sel  <= cur_sel;
                rsp_addr <= cur_addr;
            end
        end
    end
endmodule

// File: tb/tb_apb_cmd_driver.sv
// Directed bench for apb_cmd_driver: cycle-exact scenarios with hand-computed expectations.
module tb_apb_cmd_driver;
    logic        pclk = 1'b0;
    logic        Reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_sel;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        transfer, pwrite, penable;
    logic [1:0]  Psel;
    logic [4:0]  write_paddr, apb_read_paddr;
    logic [31:0] write_data, apb_read_data_out;
    logic        rsp_valid, cmd_err, busy;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_sel;
    logic [4:0]  rsp_addr;

    int checks = 0;
    int passes = 0;

    apb_cmd_driver #(.DEPTH(4), .ACCESS_CYCLES(2)) dut (
        .pclk(pclk), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .transfer(transfer), .Psel(Psel), .pwrite(pwrite), .penable(penable),
        .write_paddr(write_paddr), .apb_read_paddr(apb_read_paddr), .write_data(write_data),
        .apb_read_data_out(apb_read_data_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_sel(rsp_sel), .rsp_addr(rsp_addr),
        .cmd_err(cmd_err), .busy(busy)
    );

    always #5 pclk = ~pclk;

    // Bus monitor: logs every SETUP beat and counts pulses, on the falling edge.
    logic [44:0] bus;
    logic [44:0] last_setup = '0;
    logic [44:0] setup_q[$];
    int rsp_n = 0, err_n = 0, xfer_n = 0, xfer_falls = 0, unstable_n = 0;
    logic xfer_prev = 1'b0;
    assign bus = {pwrite, Psel, write_paddr, apb_read_paddr, write_data};

    always @(negedge pclk) begin
        if (transfer === 1'b1 && penable === 1'b0) begin
            last_setup = bus;
            setup_q.push_back(bus);
        end
        if (transfer === 1'b1 && penable === 1'b1 && bus !== last_setup) unstable_n++;
        if (rsp_valid === 1'b1) rsp_n++;
        if (cmd_err === 1'b1) err_n++;
        if (transfer === 1'b1) xfer_n++;
        if (xfer_prev && transfer !== 1'b1) xfer_falls++;
        xfer_prev = (transfer === 1'b1);
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] s, input logic [4:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_sel   = s;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        ok = (busy === 1'b0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({transfer, Psel, pwrite, penable, write_paddr, apb_read_paddr, write_data} !== 47'd0)
            $display("FAIL reset_bus: got %b %b %b %b %h %h %h want all 0",
                     transfer, Psel, pwrite, penable, write_paddr, apb_read_paddr, write_data);
        else passes++;
        checks++;
        if ({rsp_valid, rsp_data, rsp_sel, rsp_addr, cmd_err, busy} !== 42'd0)
            $display("FAIL reset_rsp: got v=%b d=%h s=%h a=%h err=%b busy=%b want all 0",
                     rsp_valid, rsp_data, rsp_sel, rsp_addr, cmd_err, busy);
        else passes++;
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready);
        else passes++;
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        int r0 = rsp_n;
        bit ok;
        drive(1'b1, 2'd1, 5'h04, 32'hA5A5_0001);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({busy, transfer} !== 2'b10) $display("FAIL wr_queued: got busy=%b transfer=%b want 1 0", busy, transfer);
        else passes++;
        tick();
        checks++;
        if ({transfer, Psel, penable, pwrite} !== 5'b1_01_0_1)
            $display("FAIL wr_setup_ctl: got %b want 10101", {transfer, Psel, penable, pwrite});
        else passes++;
        checks++;
        if ({write_paddr, apb_read_paddr, write_data} !== {5'h04, 5'h00, 32'hA5A5_0001})
            $display("FAIL wr_setup_data: got %h %h %h want 04 00 a5a50001", write_paddr, apb_read_paddr, write_data);
        else passes++;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({transfer, penable, Psel} !== 4'b11_01)
                $display("FAIL wr_access%0d: got %b want 1101", k, {transfer, penable, Psel});
            else passes++;
        end
        tick();
        checks++;
        if ({transfer, penable, Psel, write_paddr, write_data} !== {4'b0, 5'h04, 32'hA5A5_0001})
            $display("FAIL wr_idle: got t=%b e=%b s=%h a=%h d=%h want 0 0 0 04 a5a50001",
                     transfer, penable, Psel, write_paddr, write_data);
        else passes++;
        wait_idle(ok);
        checks++;
        if (!ok || rsp_n != r0) $display("FAIL wr_no_rsp: idle=%0d rsp pulses=%0d want idle and 0", ok, rsp_n - r0);
        else passes++;
    endtask

    task automatic test_read();
        int r0 = rsp_n;
        apb_read_data_out = 32'hDEAD_BEEF;
        drive(1'b0, 2'd2, 5'h01, 32'h1234_5678);
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if ({transfer, Psel, penable, pwrite} !== 5'b1_10_0_0)
            $display("FAIL rd_setup_ctl: got %b want 11000", {transfer, Psel, penable, pwrite});
        else passes++;
        checks++;
        if ({write_paddr, apb_read_paddr, write_data} !== {5'h00, 5'h01, 32'h0})
            $display("FAIL rd_setup_data: got %h %h %h want 00 01 00000000", write_paddr, apb_read_paddr, write_data);
        else passes++;
        tick();
        tick();
        apb_read_data_out = 32'h0000_0055;
        checks++;
        if ({penable, rsp_valid, apb_read_paddr} !== {2'b10, 5'h01})
            $display("FAIL rd_last_access: got en=%b rv=%b a=%h want 1 0 01", penable, rsp_valid, apb_read_paddr);
        else passes++;
        tick();
        apb_read_data_out = 32'hDEAD_BEEF;
        checks++;
        if ({rsp_valid, rsp_data, rsp_sel, rsp_addr} !== {1'b1, 32'h55, 2'd2, 5'h01})
            $display("FAIL rd_rsp: got v=%b d=%h s=%0d a=%h want 1 00000055 2 01", rsp_valid, rsp_data, rsp_sel, rsp_addr);
        else passes++;
        tick();
        checks++;
        if ({rsp_valid, rsp_data, transfer} !== {1'b0, 32'h55, 1'b0})
            $display("FAIL rd_rsp_pulse: got v=%b d=%h t=%b want 0 00000055 0", rsp_valid, rsp_data, transfer);
        else passes++;
        checks++;
        if (rsp_n - r0 != 1) $display("FAIL rd_rsp_count: got %0d pulses want 1", rsp_n - r0);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [8:0] hist = '0;
        logic [44:0] exp;
        int i = 0, cyc = 0;
        int x0 = xfer_n, f0 = xfer_falls, r0 = rsp_n, u0 = unstable_n;
        bit ok;
        setup_q.delete();
        while (i < 7 && cyc < 40) begin
            drive(1'b1, (i % 2 == 0) ? 2'd1 : 2'd2, 5'(i + 8), 32'h1000_0000 + i);
            if (cyc < 9) hist[cyc] = cmd_ready;
            if (cmd_ready === 1'b1) i++;
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (cyc != 9 || hist !== 9'b100111111)
            $display("FAIL b2b_ready: got %0d cycles hist=%b want 9 cycles 100111111", cyc, hist);
        else passes++;
        wait_idle(ok);
        checks++;
        if (!ok || setup_q.size() != 7) $display("FAIL b2b_count: idle=%0d setups=%0d want 7", ok, setup_q.size());
        else passes++;
        for (int k = 0; k < 7; k++) begin
            exp = {1'b1, (k % 2 == 0) ? 2'd1 : 2'd2, 5'(k + 8), 5'd0, 32'h1000_0000 + k};
            if (k < setup_q.size()) begin
                checks++;
                if (setup_q[k] !== exp) $display("FAIL b2b_cmd%0d: got %h want %h", k, setup_q[k], exp);
                else passes++;
            end
        end
        checks++;
        if (xfer_n - x0 != 21 || xfer_falls - f0 != 1)
            $display("FAIL b2b_continuous: got %0d transfer cycles %0d drops want 21 1", xfer_n - x0, xfer_falls - f0);
        else passes++;
        checks++;
        if (rsp_n != r0 || unstable_n != u0)
            $display("FAIL b2b_clean: got rsp=%0d unstable=%0d want 0 0", rsp_n - r0, unstable_n - u0);
        else passes++;
    endtask

    task automatic test_illegal();
        logic [44:0] exp0 = {1'b1, 2'd1, 5'h07, 5'd0, 32'h1111_1111};
        logic [44:0] exp1 = {1'b1, 2'd2, 5'h08, 5'd0, 32'h2222_2222};
        int e0 = err_n, r0 = rsp_n;
        bit ok;
        setup_q.delete();
        drive(1'b1, 2'd1, 5'h07, 32'h1111_1111); tick();
        drive(1'b1, 2'd0, 5'h03, 32'h3333_3333); tick();
        drive(1'b1, 2'd2, 5'h08, 32'h2222_2222); tick();
        drive(1'b0, 2'd3, 5'h09, 32'h0);         tick();
        cmd_valid = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || err_n - e0 != 2) $display("FAIL ill_err: idle=%0d got %0d err cycles want 2", ok, err_n - e0);
        else passes++;
        checks++;
        if (setup_q.size() != 2) $display("FAIL ill_setups: got %0d want 2", setup_q.size());
        else passes++;
        if (setup_q.size() == 2) begin
            checks++;
            if (setup_q[0] !== exp0 || setup_q[1] !== exp1)
                $display("FAIL ill_writes: got %h %h want %h %h", setup_q[0], setup_q[1], exp0, exp1);
            else passes++;
        end
        checks++;
        if (rsp_n != r0) $display("FAIL ill_rsp: got %0d pulses want 0", rsp_n - r0);
        else passes++;
    endtask

    task automatic test_reset_mid_access();
        int r0 = rsp_n;
        setup_q.delete();
        drive(1'b0, 2'd1, 5'h02, 32'h0);         tick();
        drive(1'b1, 2'd1, 5'h0A, 32'hAAAA_0000); tick();
        drive(1'b1, 2'd2, 5'h0B, 32'hBBBB_0000); tick();
        cmd_valid = 1'b0;
        checks++;
        if ({transfer, penable, Psel, apb_read_paddr} !== {4'b11_01, 5'h02})
            $display("FAIL rst_pre_access: got t=%b e=%b s=%0d a=%h want 1 1 1 02", transfer, penable, Psel, apb_read_paddr);
        else passes++;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if ({transfer, penable, Psel, rsp_valid, apb_read_paddr} !== 10'd0)
            $display("FAIL rst_bus: got t=%b e=%b s=%0d rv=%b a=%h want all 0", transfer, penable, Psel, rsp_valid, apb_read_paddr);
        else passes++;
        checks++;
        if ({cmd_ready, busy} !== 2'b10) $display("FAIL rst_fifo: got ready=%b busy=%b want 1 0", cmd_ready, busy);
        else passes++;
        for (int k = 0; k < 6; k++) tick();
        checks++;
        if (rsp_n != r0 || setup_q.size() != 1 || busy !== 1'b0)
            $display("FAIL rst_abandon: got rsp=%0d setups=%0d busy=%b want 0 1 0", rsp_n - r0, setup_q.size(), busy);
        else passes++;
    endtask

    initial begin
        Reset             = 1'b1;
        cmd_valid         = 1'b0;
        cmd_write         = 1'b0;
        cmd_sel           = 2'd0;
        cmd_addr          = 5'd0;
        cmd_wdata         = 32'd0;
        apb_read_data_out = 32'hDEAD_BEEF;
        test_reset();
        test_single_write();
        test_read();
        test_back_to_back();
        test_illegal();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
